// File: rtl/rnn_pkg.sv
// Shared widths and status-flag positions for the RNN core and its feeder.
package rnn_pkg;

    localparam int RNN_X_W    = 32;
    localparam int RNN_LANES  = 4;
    localparam int RNN_BYTE_W = RNN_X_W / RNN_LANES;

    // Sticky-flag bit positions in the core status register
    localparam int RNN_ST_UNDERFLOW = 0;
    localparam int RNN_ST_W         = 8;

    typedef logic [$clog2(RNN_LANES)-1:0] lane_t;

endpackage

// File: rtl/rnn_feed_fifo.sv
// Generic show-ahead circular FIFO with registered level count.
// The head word is visible on rdata while not empty, zero otherwise.
module rnn_feed_fifo
    import rnn_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LVL_W = 5,
    parameter int W     = RNN_X_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             push,
    input  logic [W-1:0]     wdata,
    input  logic             pop,
    output logic [W-1:0]     rdata,
    output logic [LVL_W-1:0] level,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign do_pop  = pop && !empty && !clr;
    assign do_push = push && (!full || do_pop) && !clr;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + LVL_W'(1);
            end else if (do_pop && !do_push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/rnn_input_feeder.sv
// Byte-stream to 32-bit input-vector feeder for the RNN core.
// Define RNN_FEED_STATS_EN to build the delivered-word counter on frames_out.
module rnn_input_feeder
    import rnn_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LVL_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic [7:0]         s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic               ready,
    input  logic               i_en,
    output logic [RNN_X_W-1:0] idata,
    output logic [LVL_W-1:0]   level,
    output logic               err_underflow,
    output logic [15:0]        frames_out
);

    localparam lane_t LAST = lane_t'(RNN_LANES - 1);

    lane_t                          byte_cnt;
    logic [RNN_X_W-RNN_BYTE_W-1:0] word_q;
    logic                           fifo_empty;
    logic                           fifo_full;
    logic                           accept;
    logic                           push;
    logic                           pop;

    // Only the completing byte needs space; no bypass from a same-cycle pop
    assign s_ready = (byte_cnt != LAST) || !fifo_full;
    assign accept  = s_valid && s_ready && !flush;
    assign push    = accept && (byte_cnt == LAST);
    assign pop     = i_en && !fifo_empty && !flush;
    assign ready   = !fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt <= '0;
            word_q   <= '0;
        end else if (flush) begin
            byte_cnt <= '0;
        end else if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            unique case (byte_cnt)
                2'd0:    word_q[7:0]   <= s_data;
                2'd1:    word_q[15:8]  <= s_data;
                2'd2:    word_q[23:16] <= s_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_underflow <= 1'b0;
        end else if (i_en && fifo_empty && !flush) begin
            err_underflow <= 1'b1;
        end
    end

    rnn_feed_fifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W),
        .W     (RNN_X_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .push  (push),
        .wdata ({s_data, word_q}),
        .pop   (pop),
        .rdata (idata),
        .level (level),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

`ifdef RNN_FEED_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frames_out <= '0;
        end else if (pop && (frames_out != 16'hFFFF)) begin
            frames_out <= frames_out + 16'd1;
        end
    end
`else
    assign frames_out = '0;
`endif

endmodule

// File: tb/tb_rnn_input_feeder.sv
// Scoreboard bench for rnn_input_feeder: random byte/pop/flush traffic vs a queue model.
module tb_rnn_input_feeder;

    localparam int DEPTH = 16;
    localparam int LVL_W = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        ready;
    logic        i_en;
    logic [31:0] idata;
    logic [LVL_W-1:0] level;
    logic        err_underflow;
    logic [15:0] frames_out;

    rnn_input_feeder #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .ready         (ready),
        .i_en          (i_en),
        .idata         (idata),
        .level         (level),
        .err_underflow (err_underflow),
        .frames_out    (frames_out)
    );

    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    logic [7:0]  bq[$];
    logic        exp_err;
    int          exp_frames;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] head();
        return (exp_q.size() != 0) ? exp_q[0] : 32'h0;
    endfunction

    // Monitor: compare visible state, then retire the head word the core takes
    always @(negedge clk) begin
        chk("level", 32'(level), 32'(exp_q.size()));
        chk("ready", 32'(ready), 32'(exp_q.size() != 0));
        chk("s_ready", 32'(s_ready),
            32'((bq.size() != 3) || (exp_q.size() < DEPTH)));
        chk("err_underflow", 32'(err_underflow), 32'(exp_err));
`ifdef RNN_FEED_STATS_EN
        chk("frames_out", 32'(frames_out), 32'(exp_frames));
`else
        chk("frames_out", 32'(frames_out), 32'h0);
`endif
        if (!reset && i_en && !flush && exp_q.size() != 0) begin
            chk("pop_word", idata, exp_q.pop_front());
        end else begin
            chk("idata", idata, head());
        end
    end

    task automatic cycle(input logic v, input logic [7:0] d,
                         input logic en, input logic fl);
        logic acc;
        logic popv;
        logic und;
        s_valid = v;
        s_data  = d;
        i_en    = en;
        flush   = fl;
        acc  = v && !fl && ((bq.size() != 3) || (exp_q.size() < DEPTH));
        popv = en && !fl && (exp_q.size() != 0);
        und  = en && !fl && (exp_q.size() == 0);
        @(posedge clk);
        #1;
        if (fl) begin
            exp_q.delete();
            bq.delete();
        end else begin
            if (acc) begin
                bq.push_back(d);
                if (bq.size() == 4) begin
                    exp_q.push_back({bq[3], bq[2], bq[1], bq[0]});
                    bq.delete();
                end
            end
            if (und) exp_err = 1'b1;
            if (popv && exp_frames < 16'hFFFF) exp_frames++;
        end
    endtask

    task automatic pulse_reset();
        s_valid = 1'b0;
        i_en    = 1'b0;
        flush   = 1'b0;
        reset   = 1'b1;
        exp_q.delete();
        bq.delete();
        exp_err    = 1'b0;
        exp_frames = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) cycle(1'b1, w[8*i +: 8], 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        s_valid = 1'b0;
        s_data = 8'h00;
        i_en = 1'b0;
        exp_err = 1'b0;
        exp_frames = 0;
        @(posedge clk);
        #1;
        pulse_reset();
        idle(1);

        // First word assembles little-endian
        send_word(32'h12345678);
        chk("dir_first_word", idata, 32'h12345678);

        // Two queued, pop twice
        send_word(32'hCAFEF00D);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("dir_second_head", idata, 32'hCAFEF00D);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("dir_empty_idata", idata, 32'h0);

        // Fill, stall on fourth byte, pop releases it
        for (int i = 0; i < DEPTH; i++) send_word(32'hA0000000 + 32'(i));
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(i + 1), 1'b0, 1'b0);
        chk("dir_full_stall", 32'(s_ready), 32'h0);
        cycle(1'b1, 8'h44, 1'b0, 1'b0);
        cycle(1'b1, 8'h44, 1'b1, 1'b0);
        chk("dir_ready_after_pop", 32'(s_ready), 32'h1);
        cycle(1'b1, 8'h44, 1'b0, 1'b0);
        chk("dir_level_full", 32'(level), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Push and pop on the same edge with one word queued
        send_word(32'h11111111);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'h23, 1'b1, 1'b0);
        chk("dir_pushpop_word", idata, 32'h23222120);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Underflow is sticky through flush
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("dir_underflow", 32'(err_underflow), 32'h1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("dir_underflow_flush", 32'(err_underflow), 32'h1);

        // Flush discards a partial word
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        cycle(1'b1, 8'hBB, 1'b0, 1'b0);
        cycle(1'b1, 8'hCC, 1'b1, 1'b1);
        send_word(32'h00000001);
        chk("dir_flush_partial", idata, 32'h00000001);
        for (int i = 0; i < 4; i++) send_word(32'h5 + 32'(i));
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        pulse_reset();
        chk("dir_reset_err", 32'(err_underflow), 32'h0);

        // Random traffic with varying pop pressure and a mid-run reset
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 800; i++) begin
                logic v;
                logic en;
                logic fl;
                v  = ($urandom_range(0, 3) != 0);
                en = ($urandom_range(0, 9) < 2 * ph + 1);
                fl = ($urandom_range(0, 99) == 0);
                cycle(v, 8'($urandom), en, fl);
                if (ph == 2 && i == 400) begin
                    #2;
                    pulse_reset();
                end
            end
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rnn_input_feeder.md
Name: rnn_input_feeder

Overview:
- Upstream stage of the RNN core.
- Accepts a byte stream from the host/testbench with a valid/ready handshake and assembles little-endian 32-bit input vectors, one bit per input neuron.
- Buffers the vectors in a show-ahead FIFO and presents the head word on idata.
- Raises ready while data is queued and pops one word per i_en pulse from the core.

Parameters:
- DEPTH, 16, FIFO depth in 32-bit words; power of two, ≥2.
- LVL_W, 5, level width; equals clog2(DEPTH)+1.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  synchronous clear of FIFO and byte assembler; does not clear sticky flags.
- s_data  in  8  input byte.
- s_valid  in  1  s_data valid.
- s_ready  out  1  feeder accepts byte this cycle.
- ready  out  1  to core: at least one word queued.
- i_en  in  1  from core: consume head word this cycle.
- idata  out  32  to core: head word; 0 when empty.
- level  out  LVL_W  words currently queued.
- err_underflow  out  1  sticky: i_en seen while empty.
- frames_out  out  16  delivered-word count (optional feature).

Behaviour:
- Reset values:
  - s_ready=1, ready=0, idata=0, level=0, err_underflow=0, frames_out=0.
  - Byte counter 0; pointers 0.
- Byte assembler:
  - 2-bit byte_cnt.
  - On s_valid&&s_ready, s_data is written to lane byte_cnt (first byte → bits 7:0, fourth → 31:24) and byte_cnt increments, wrapping 3→0.
  - On the fourth byte the completed word, including that byte, is pushed the same edge.
- s_ready = (byte_cnt!=3) || (level<DEPTH).
  - This is combinational from registered state.
  - A same-cycle pop does not raise s_ready when full: no bypass.
- FIFO:
  - Circular buffer; rd_ptr/wr_ptr wrap modulo DEPTH.
  - level is a registered count.
  - Push and pop in the same cycle leave level unchanged; both pointers advance.
- idata = mem[rd_ptr] when level!=0, else 32'h0. This is show-ahead.
  - The core samples idata at the edge at which i_en is high, so the head must already be valid while i_en is asserted.
- Pop:
  - At a rising edge with i_en=1 and level!=0, rd_ptr advances and level decrements.
  - i_en with level==0: no pointer change; err_underflow set and held until reset.
- ready = (level!=0), combinational from the registered level.
  - The core latches ready into busy.
  - The feeder places no constraint on how long ready stays high.
- flush:
  - At the edge: byte_cnt=0, pointers=0, level=0. A partial word is discarded.
  - A byte or i_en in the same cycle is ignored.
  - Takes priority over push/pop.
- reset mid-operation: all state returns to reset values immediately (asynchronous). The partial word is lost.
- Latency: the last byte is accepted at edge E; ready=1 and idata valid from just after E.

Optional Feature:
- Macro: RNN_FEED_STATS_EN.
- With it: frames_out is a 16-bit counter.
  - Increments on every successful pop.
  - Saturates at 16'hFFFF.
  - Cleared by reset only, not by flush.
- Without it: frames_out is tied to 0; no counter flops.

Decomposition:
- Shared package rnn_pkg holds:
  - RNN_X_W=32 (input vector width) and the byte-lane count 4.
  - The sticky-flag bit positions used by the status register.
- One sub-module is natural: rnn_feed_fifo, a generic show-ahead FIFO with DEPTH, width 32, push, pop, level and empty/full.
- The byte assembler, underflow flag and stats counter stay in rnn_input_feeder.

Test Plan:
- Bytes 0x78,0x56,0x34,0x12 with s_valid each cycle → after 4th edge ready=1, level=1, idata=32'h12345678.
- Two words queued, i_en pulsed one cycle → idata switches to second word at the next edge; level 2→1; ready stays 1. Second pulse → level 0, ready=0, idata=0.
- Fill 16 words and send 3 more bytes → s_ready=0 at byte_cnt=3.
  - One i_en pop → s_ready=1 the following cycle; 4th byte accepted; level=16.
- Push completes on the same edge as i_en with level=1 → level stays 1; idata becomes the newly pushed word.
- i_en with FIFO empty → err_underflow=1, level 0. Flag stays 1 after flush; clears only on reset.
- Send 2 bytes, assert flush, then send 0x01,0x00,0x00,0x00 → idata=32'h00000001, proving the partial word was discarded.
- With RNN_FEED_STATS_EN, 5 pops → frames_out=5.
